// File: rtl/spi_nor_pkg.sv
// Shared definitions for the SPI NOR flash path.
// Command codes, frame field positions and the target FSM states.
package spi_nor_pkg;

   localparam logic [7:0] CMD_READ   = 8'h01;
   localparam logic [7:0] CMD_WRITE  = 8'h02;
   localparam logic [7:0] CMD_STATUS = 8'h05;

   localparam int CMD_LSB  = 0;
   localparam int CMD_MSB  = 7;
   localparam int ADDR_LSB = 8;
   localparam int ADDR_MSB = 31;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CMD,
      S_DATA,
      S_DONE
   } state_t;

   function automatic logic [7:0] get_cmd(
      input logic [31:0] w
   );
      return w[CMD_MSB:CMD_LSB];
   endfunction

   function automatic logic [23:0] get_addr(
      input logic [31:0] w
   );
      return w[ADDR_MSB:ADDR_LSB];
   endfunction

endpackage

// File: rtl/spi_norflash_target_if.sv
// Word-wide SPI link between controller and flash target.
// The controller is the master; the target is the slave.
interface spi_norflash_target_if;

   logic        s_clk;
   logic        s_css;
   logic [31:0] s_mosi;
   logic [31:0] s_miso;

   modport master (
      output s_clk,
      output s_css,
      output s_mosi,
      input  s_miso
   );

   modport slave (
      input  s_clk,
      input  s_css,
      input  s_mosi,
      output s_miso
   );

endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer plus a history flop for edge pulses.
// RST_VAL lets an idle-high input come out of reset without an edge.
module spi_sync_edge #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [2:0] sr;

   // shift the async input through sync and history flops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sr <= {3{RST_VAL}};
      else        sr <= {sr[1:0], d};
   end

   assign q    = sr[1];
   assign rise = sr[1] & ~sr[2];
   assign fall = ~sr[1] & sr[2];

endmodule

// File: rtl/spi_norflash_target.sv
// SPI-side NOR flash target: small resettable word array,
// READ/WRITE/STATUS framing and a program-busy timer.
module spi_norflash_target
   import spi_nor_pkg::*;
#(
   parameter int DEPTH       = 16,
   parameter int AW          = 4,
   parameter int PROG_CYCLES = 8
) (
   input  logic                       p_clk,
   input  logic                       p_resetn,
   spi_norflash_target_if.slave       spi,
   output logic                       busy,
   output logic                       drop
);

   localparam int PW = $clog2(PROG_CYCLES + 1);

   logic          sclk_q, sclk_rise, sclk_fall;
   logic          css_q, css_rise, css_fall;
   logic          unused_sync;
   logic          edge_ok;
   state_t        state, state_d;
   logic          lat_cmd, exec;
   logic [7:0]    cmd_q;
   logic [23:0]   addr_q;
   logic [7:0]    cur_cmd;
   logic [23:0]   cur_addr;
   logic          in_range;
   logic [AW-1:0] idx;
   logic [31:0]   rd_word;
   logic          is_write;
   logic          wr_ok, wr_rej;
   logic [31:0]   miso_q;
   logic [PW-1:0] prog_cnt;
   logic [31:0]   mem [DEPTH];

   spi_sync_edge #(.RST_VAL(1'b0)) u_sclk (
      .clk   (p_clk),
      .rst_n (p_resetn),
      .d     (spi.s_clk),
      .q     (sclk_q),
      .rise  (sclk_rise),
      .fall  (sclk_fall)
   );

   spi_sync_edge #(.RST_VAL(1'b1)) u_css (
      .clk   (p_clk),
      .rst_n (p_resetn),
      .d     (spi.s_css),
      .q     (css_q),
      .rise  (css_rise),
      .fall  (css_fall)
   );

   assign unused_sync = sclk_q ^ sclk_fall;

   // a deselected target ignores clock edges, so a
   // same-cycle css rise always beats sclk_rise
   assign edge_ok = sclk_rise & ~css_q;

   // FSM register
   always_ff @(posedge p_clk or negedge p_resetn) begin
      if (!p_resetn) state <= S_IDLE;
      else           state <= state_d;
   end

   // next state plus the two per-frame edge strobes
   always_comb begin
      state_d = state;
      lat_cmd = 1'b0;
      exec    = 1'b0;
      if (css_rise) begin
         state_d = S_IDLE;
      end else begin
         unique case (state)
            S_IDLE: if (css_fall) state_d = S_CMD;
            S_CMD: if (edge_ok) begin
               lat_cmd = 1'b1;
               state_d = S_DATA;
            end
            S_DATA: if (edge_ok) begin
               exec    = 1'b1;
               state_d = S_DONE;
            end
            default: ;
         endcase
      end
   end

   // command word holds cmd/addr for the data edge
   always_ff @(posedge p_clk or negedge p_resetn) begin
      if (!p_resetn) begin
         cmd_q  <= '0;
         addr_q <= '0;
      end else if (lat_cmd) begin
         cmd_q  <= get_cmd(spi.s_mosi);
         addr_q <= get_addr(spi.s_mosi);
      end
   end

   assign cur_cmd  = lat_cmd ? get_cmd(spi.s_mosi)
                             : cmd_q;
   assign cur_addr = lat_cmd ? get_addr(spi.s_mosi)
                             : addr_q;
   assign in_range = (cur_addr >> AW) == 24'd0;
   assign idx      = cur_addr[AW-1:0];
   assign rd_word  = in_range ? mem[idx] : 32'd0;
   assign is_write = exec && (cur_cmd == CMD_WRITE);
   assign wr_ok    = is_write && in_range && !busy;
   assign wr_rej   = is_write && !(in_range && !busy);

   // response word; unknown commands leave it untouched
   always_ff @(posedge p_clk or negedge p_resetn) begin
      if (!p_resetn) begin
         miso_q <= '0;
      end else if (lat_cmd || exec) begin
         unique case (1'b1)
            (cur_cmd == CMD_READ):   miso_q <= rd_word;
            (cur_cmd == CMD_STATUS): miso_q <= {31'b0, busy};
            default: ;
         endcase
      end
   end

   assign spi.s_miso = miso_q;

   // program timer; busy follows it directly
   always_ff @(posedge p_clk or negedge p_resetn) begin
      if (!p_resetn)           prog_cnt <= '0;
      else if (wr_ok)          prog_cnt <= PW'(PROG_CYCLES);
      else if (prog_cnt != '0) prog_cnt <= prog_cnt - PW'(1);
   end

   assign busy = (prog_cnt != '0);

   // single-cycle rejection pulse on the data edge
   always_ff @(posedge p_clk or negedge p_resetn) begin
      if (!p_resetn) drop <= 1'b0;
      else           drop <= wr_rej;
   end

   // register-file array, cleared by reset
   always_ff @(posedge p_clk or negedge p_resetn) begin
      if (!p_resetn) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (wr_ok) begin
         mem[idx] <= spi.s_mosi;
      end
   end

endmodule

// File: tb/tb_spi_norflash_target.sv
// Randomized bench for spi_norflash_target with a cycle-counted
// reference model of the array, busy window, drop and s_miso.
module tb_spi_norflash_target;
   import spi_nor_pkg::*;

   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int P     = 40;

   logic p_clk = 1'b0;
   logic p_resetn;
   logic busy, drop;

   spi_norflash_target_if bus ();

   spi_norflash_target #(
      .DEPTH       (DEPTH),
      .AW          (AW),
      .PROG_CYCLES (P)
   ) dut (
      .p_clk    (p_clk),
      .p_resetn (p_resetn),
      .spi      (bus),
      .busy     (busy),
      .drop     (drop)
   );

   always #5 p_clk = ~p_clk;

   int cyc = 0;
   always @(posedge p_clk) cyc <= cyc + 1;

   int vectors = 0;
   int errors  = 0;

   logic [31:0] mmem [DEPTH];
   logic [31:0] exp_miso;
   logic [7:0]  mcmd;
   logic [23:0] maddr;
   int          last_e = -1000;
   int          drop_e = -1;
   bit          chk_en = 1'b0;
   int          drop_seen = 0;

   // busy must cover cycles last_e..last_e+P-1; drop only drop_e
   always @(negedge p_clk) begin
      if (chk_en) begin
         vectors++;
         if (busy !== ((cyc >= last_e) && (cyc < last_e + P))) begin
            errors++;
            $display("FAIL busy_window cyc=%0d got %b", cyc, busy);
         end
         vectors++;
         if (drop !== (cyc == drop_e)) begin
            errors++;
            $display("FAIL drop_pulse cyc=%0d got %b", cyc, drop);
         end
         if (drop === 1'b1) drop_seen++;
      end
   end

   task automatic wait_n(input int n);
      repeat (n) @(negedge p_clk);
   endtask

   function automatic bit busy_at(input int e);
      return (e - 1 >= last_e) && (e - 1 < last_e + P);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
      exp_miso = '0;
      mcmd     = '0;
      maddr    = '0;
      last_e   = -1000;
      drop_e   = -1;
   endtask

   task automatic model_edge(input int i, input logic [31:0] w,
                             input int e);
      bit inr;
      if (i == 0) begin
         mcmd  = w[7:0];
         maddr = w[31:8];
      end
      if (i > 1) return;
      inr = (maddr < DEPTH);
      case (mcmd)
         CMD_READ:   exp_miso = inr ? mmem[maddr[AW-1:0]] : 32'd0;
         CMD_STATUS: exp_miso = {31'b0, busy_at(e)};
         CMD_WRITE:
            if (i == 1) begin
               if (inr && !busy_at(e)) begin
                  mmem[maddr[AW-1:0]] = w;
                  last_e = e;
               end else begin
                  drop_e = e;
               end
            end
         default: ;
      endcase
   endtask

   task automatic word_edge(input int i, input logic [31:0] w);
      bus.s_mosi = w;
      wait_n(2);
      model_edge(i, w, cyc + 3);
      bus.s_clk = 1'b1;
      wait_n(4);
      vectors++;
      if (bus.s_miso !== exp_miso) begin
         errors++;
         $display("FAIL miso_word%0d got %h want %h",
                  i, bus.s_miso, exp_miso);
      end
      bus.s_clk = 1'b0;
      wait_n(4);
   endtask

   task automatic frame(input logic [31:0] w0, input logic [31:0] w1,
                        input logic [31:0] w2, input int nw);
      bus.s_css = 1'b0;
      wait_n(4);
      for (int i = 0; i < nw; i++)
         word_edge(i, (i == 0) ? w0 : (i == 1) ? w1 : w2);
      bus.s_css = 1'b1;
      wait_n(4);
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 4 * P; k++) begin
         if (busy === 1'b0) break;
         wait_n(1);
      end
      vectors++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_timeout got busy=%b want 0", busy);
      end
   endtask

   task automatic test_reset();
      p_resetn   = 1'b0;
      bus.s_clk  = 1'b0;
      bus.s_css  = 1'b1;
      bus.s_mosi = '0;
      wait_n(3);
      vectors++;
      if (bus.s_miso !== 32'd0) begin
         errors++;
         $display("FAIL reset_miso got %h want 0", bus.s_miso);
      end
      vectors++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_busy got %b want 0", busy);
      end
      vectors++;
      if (drop !== 1'b0) begin
         errors++;
         $display("FAIL reset_drop got %b want 0", drop);
      end
      model_reset();
      p_resetn = 1'b1;
      wait_n(3);
      chk_en = 1'b1;
   endtask

   task automatic test_write_read();
      frame({24'h0, CMD_WRITE}, 32'hFF00FF00, '0, 2);
      wait_idle();
      frame({24'h0, CMD_READ}, '0, '0, 2);
      vectors++;
      if (bus.s_miso !== 32'hFF00FF00) begin
         errors++;
         $display("FAIL write_read got %h want ff00ff00", bus.s_miso);
      end
   endtask

   task automatic test_busy_reject();
      int d0;
      wait_idle();
      d0 = drop_seen;
      frame({24'h3, CMD_WRITE}, 32'h12345678, '0, 2);
      frame({24'h3, CMD_WRITE}, 32'hDEADBEEF, '0, 2);
      wait_idle();
      frame({24'h3, CMD_READ}, '0, '0, 2);
      vectors++;
      if (drop_seen - d0 !== 1) begin
         errors++;
         $display("FAIL busy_drops got %0d want 1", drop_seen - d0);
      end
      vectors++;
      if (bus.s_miso !== 32'h12345678) begin
         errors++;
         $display("FAIL busy_keep got %h want 12345678", bus.s_miso);
      end
   endtask

   task automatic test_status();
      wait_idle();
      frame({24'h5, CMD_WRITE}, $urandom, '0, 2);
      frame({24'h0, CMD_STATUS}, '0, '0, 2);
      vectors++;
      if (bus.s_miso !== 32'd1) begin
         errors++;
         $display("FAIL status_busy got %h want 1", bus.s_miso);
      end
      wait_idle();
      frame({24'h0, CMD_STATUS}, '0, '0, 2);
      vectors++;
      if (bus.s_miso !== 32'd0) begin
         errors++;
         $display("FAIL status_idle got %h want 0", bus.s_miso);
      end
   endtask

   task automatic test_out_of_range();
      int d0;
      logic [31:0] m0;
      wait_idle();
      m0 = mmem[0];
      d0 = drop_seen;
      frame({24'h000100, CMD_WRITE}, $urandom, '0, 2);
      vectors++;
      if (drop_seen - d0 !== 1) begin
         errors++;
         $display("FAIL oor_drop got %0d want 1", drop_seen - d0);
      end
      frame({24'h000100, CMD_READ}, '0, '0, 2);
      vectors++;
      if (bus.s_miso !== 32'd0) begin
         errors++;
         $display("FAIL oor_read got %h want 0", bus.s_miso);
      end
      frame({24'h0, CMD_READ}, '0, '0, 2);
      vectors++;
      if (bus.s_miso !== m0) begin
         errors++;
         $display("FAIL oor_mem0 got %h want %h", bus.s_miso, m0);
      end
   endtask

   task automatic test_abort();
      int d0;
      logic [31:0] m7;
      wait_idle();
      m7 = mmem[7];
      d0 = drop_seen;
      frame({24'h7, CMD_WRITE}, '0, '0, 1);
      bus.s_mosi = 32'hA5A5A5A5;
      vectors++;
      if (drop_seen !== d0) begin
         errors++;
         $display("FAIL abort_drop got %0d want 0", drop_seen - d0);
      end
      vectors++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_busy got %b want 0", busy);
      end
      frame({24'h7, CMD_READ}, '0, '0, 2);
      vectors++;
      if (bus.s_miso !== m7) begin
         errors++;
         $display("FAIL abort_mem got %h want %h", bus.s_miso, m7);
      end
   endtask

   task automatic test_random();
      logic [7:0]  c;
      logic [23:0] a;
      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 3))
            0:       c = CMD_READ;
            1:       c = CMD_WRITE;
            2:       c = CMD_STATUS;
            default: c = 8'h80 | 8'($urandom_range(0, 127));
         endcase
         if ($urandom_range(0, 7) == 0) a = 24'($urandom);
         else a = 24'($urandom_range(0, DEPTH - 1));
         frame({a, c}, $urandom, $urandom, $urandom_range(1, 3));
         if ($urandom_range(0, 2) == 0) wait_idle();
      end
   endtask

   task automatic test_reset_mid_busy();
      logic [23:0] a;
      logic [31:0] d;
      int e;
      wait_idle();
      a = 24'($urandom_range(0, DEPTH - 1));
      d = $urandom | 32'h1;
      bus.s_css = 1'b0;
      wait_n(4);
      word_edge(0, {a, CMD_WRITE});
      bus.s_mosi = d;
      wait_n(2);
      e = cyc + 3;
      model_edge(1, d, e);
      bus.s_clk = 1'b1;
      while (cyc < e + 2) wait_n(1);
      vectors++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL rmb_pre_busy got %b want 1", busy);
      end
      chk_en   = 1'b0;
      p_resetn = 1'b0;
      #1;
      vectors++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL rmb_busy got %b want 0", busy);
      end
      vectors++;
      if (bus.s_miso !== 32'd0) begin
         errors++;
         $display("FAIL rmb_miso got %h want 0", bus.s_miso);
      end
      model_reset();
      wait_n(2);
      bus.s_clk = 1'b0;
      bus.s_css = 1'b1;
      wait_n(2);
      p_resetn = 1'b1;
      wait_n(3);
      chk_en = 1'b1;
      frame({a, CMD_READ}, '0, '0, 2);
      vectors++;
      if (bus.s_miso !== 32'd0) begin
         errors++;
         $display("FAIL rmb_read got %h want 0", bus.s_miso);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_busy_reject();
      test_status();
      test_out_of_range();
      test_abort();
      test_random();
      test_reset_mid_busy();
      wait_n(4);
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, errors);
      $finish;
   end

endmodule

// File: doc/spi_norflash_target.md
# spi_norflash_target

Synthesizable SPI-side NOR flash target for the APB-to-SPI NOR flash controller. Sits directly downstream of `controller`: it consumes `s_mosi`/`s_clk`/`s_css` and drives `s_miso` with the same 32-bit word-wide framing the controller emits. It holds a small word array, models program latency with a busy flag, and lets the controller be exercised on FPGA or in a bench without a behavioural flash.

## Interface
- `DEPTH`, 16: number of 32-bit words in the array; power of two, 2..256.
- `AW`, 4: index width, equal to log2(DEPTH).
- `PROG_CYCLES`, 8: `p_clk` cycles `busy` stays high after an accepted write; must be ≥1.
- `p_clk`  in  1  single block clock, same clock as the controller.
- `p_resetn`  in  1  asynchronous, active-low reset.
- `s_clk`  in  1  SPI clock from the controller; sampled, not used as a clock.
- `s_css`  in  1  chip select, active low.
- `s_mosi`  in  32  word from the controller.
- `s_miso`  out  32  word to the controller.
- `busy`  out  1  program in progress.
- `drop`  out  1  one-cycle pulse when a write is rejected.

## Operation
- Input sampling: `s_clk` and `s_css` each pass through a 2-flop synchronizer. The rising edge of the synced `s_clk` is `sclk_rise`, a 1-cycle pulse. `s_mosi` is captured on `sclk_rise`; it is stable because the controller holds it across the SPI cycle.
- Frame:
  - Starts on the synced `s_css` falling edge. This clears `word_cnt` to 0.
  - While `s_css` is high, `sclk_rise` is ignored and `word_cnt` holds at 0.
- States (FSM): IDLE, CMD, DATA, DONE.
  - IDLE → CMD on `s_css` falling.
  - CMD: first `sclk_rise` latches `cmd = s_mosi[7:0]` and `addr = s_mosi[31:8]`, then → DATA.
  - DATA: second `sclk_rise` executes the command, then → DONE.
  - DONE: further words are ignored and `s_miso` holds.
  - Any state → IDLE on `s_css` rising. A frame aborted in CMD or DATA performs no memory write.
- Address range: `addr` is in range iff `addr[23:AW] == 0`. The index is `addr[AW-1:0]`.
- Commands:
  - 0x01 READ: at the CMD latch, `s_miso` ← mem[idx] if in range, else 0. It is loaded again at the DATA edge. Reads are allowed while `busy` is high.
  - 0x02 WRITE: at the DATA edge, if in range and `busy == 0`, then mem[idx] ← `s_mosi`, `busy` ← 1 and `prog_cnt` ← PROG_CYCLES. Otherwise `drop` pulses and the array is unchanged.
  - 0x05 STATUS: at the CMD latch and at the DATA edge, `s_miso` ← {31'b0, `busy`}.
  - Any other code: no-op; `s_miso` holds its previous value.
- Busy: `prog_cnt` decrements each cycle while nonzero. `busy` deasserts the cycle it reaches 0. A write is never accepted in the cycle `busy` clears; it must arrive in a later edge.
- Reset, effective immediately and also mid-frame or mid-busy:
  - `s_miso` = 0, `busy` = 0, `drop` = 0.
  - FSM = IDLE, all array words = 0, counters = 0.

## Timing
- Sampling constraint: `s_clk` high and low phases are each ≥2 `p_clk` cycles.
- Edge to update latency: from the `s_clk` pin rise to the `s_miso` update is 3 `p_clk` cycles (2 sync flops plus 1 register).
- `s_miso` requirements:
  - Valid before the next `s_clk` rise.
  - Constant between updates.
  - Never updated while `s_css` is high.
- `drop` is high exactly 1 cycle, aligned with the DATA-edge cycle.
- `busy` is high for exactly PROG_CYCLES cycles, starting the cycle after the accepted DATA edge.
- Simultaneous `s_css` rise and `sclk_rise` in the same cycle: deselect wins and the edge is ignored.

## Structure
- Shared package `spi_nor_pkg` holds:
  - Command constants CMD_READ = 8'h01, CMD_WRITE = 8'h02, CMD_STATUS = 8'h05.
  - The state enum.
  - The field positions CMD [7:0] and ADDR [31:8], which are also used by the controller.
- One sub-module, `spi_sync_edge`: a 2-flop synchronizer with rise and fall pulse outputs, instantiated for `s_clk` and `s_css`.
- The array is a register file, not an inferred RAM, because it needs reset.

## Test plan
- Write then read: frame {0x000000, 0x02}, 0xFF00FF00, wait for `busy` to clear, then frame {0x000000, 0x01}. Required: `s_miso` = 0xFF00FF00 before the second `s_clk` rise of the read frame.
- Busy rejection: write 0x12345678 to addr 3, then immediately write 0xDEADBEEF to addr 3 while `busy` is high. Required: `drop` pulses once, and a later read returns 0x12345678.
- Status: issue STATUS during `busy` → `s_miso` = 0x00000001. Issue STATUS again after PROG_CYCLES → `s_miso` = 0x00000000.
- Out of range: write to addr 0x000100 with DEPTH = 16 → `drop` pulses. A read of the same address returns 0, and mem[0] is unchanged.
- Abort: raise `s_css` after the command word of a write frame, before the data word. Required: no `drop`, `busy` stays 0, and the array is unchanged.
- Reset mid-busy: assert `p_resetn` low 2 cycles after an accepted write. Required: `busy` = 0 and `s_miso` = 0 immediately, and a later read of that address returns 0.
